signed_divider: RTL and testbench

Multicycle iterative divider for the MIPS execute stage. It implements DIV (signed) and DIVU (unsigned) and produces a quotient for LO and a remainder for HI.
- Restoring shift-subtract, one quotient bit per clock.
- Uses a start/busy/done handshake so the pipeline can stall on HI/LO reads.
- It consumes the same operand pair as the ALU comparators (data_in1 = dividend, data_in2 = divisor).

---
 rtl/signed_divider_if.sv | 24 ++
 rtl/signed_divider.sv | 130 +++++++++++++
 tb/tb_signed_divider.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/signed_divider_if.sv
// Handshake and operand/result bundle between the execute stage and the iterative divider.
interface signed_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] data_in1;
    logic [WIDTH-1:0] data_in2;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, is_signed, data_in1, data_in2,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, is_signed, data_in1, data_in2,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/signed_divider.sv
// Restoring shift-subtract divider for DIV/DIVU: one quotient bit per clock,
// quotient for LO and remainder for HI, with a start/busy/done handshake.
module signed_divider #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst_b,
    signed_divider_if.slave bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             negQuo_q, negQuo_d;
    logic             negRem_q, negRem_d;
    logic             divZero_q, divZero_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, done_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] in1Mag, in2Mag;

    // The remainder is always below the divisor magnitude, so the low WIDTH bits of the difference are exact.
    assign shifted = {acc_q, dvd_q[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dvs_q});
    assign diff    = shifted[WIDTH-1:0] - dvs_q;

    assign in1Mag = (bus.is_signed && bus.data_in1[WIDTH-1]) ? -bus.data_in1 : bus.data_in1;
    assign in2Mag = (bus.is_signed && bus.data_in2[WIDTH-1]) ? -bus.data_in2 : bus.data_in2;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        negQuo_d  = negQuo_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    negQuo_d  = bus.is_signed & (bus.data_in1[WIDTH-1] ^ bus.data_in2[WIDTH-1]);
                    negRem_d  = bus.is_signed & bus.data_in1[WIDTH-1];
                    divZero_d = (bus.data_in2 == '0);
                    dvd_d     = in1Mag;
                    dvs_d     = in2Mag;
                    acc_d     = '0;
                    count_d   = CW'(WIDTH - 1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_d   = fits ? diff : shifted[WIDTH-1:0];
                dvd_d   = {dvd_q[WIDTH-2:0], fits};
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // With a zero divisor the accumulator holds |dividend|, so the sign fix restores the original value.
                quo_d   = divZero_q ? '1 : (negQuo_q ? -dvd_q : dvd_q);
                rem_d   = negRem_q ? -acc_q : acc_q;
                dbz_d   = divZero_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy and done are registered decodes of the state, so each appears one cycle after its state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            negQuo_q  <= negQuo_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            dbz_q     <= dbz_d;
            busy_q    <= (state_q == CALC) || (state_q == FIX);
            done_q    <= (state_q == DONE);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;

endmodule

// File: tb/tb_signed_divider.sv
// Directed and randomized bench for signed_divider with a scoreboard of expected
// quotient/remainder/div_by_zero entries consumed on each done pulse.
module tb_signed_divider;

    logic clk;
    logic rst_b;
    int   totalCount;
    int   badCount;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t  sb[$];
    string tagQ[$];

    signed_divider_if #(.WIDTH(32)) bus ();

    signed_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) else begin
            badCount++;
            $error("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference uses the language's own truncating division, not a bit-serial algorithm.
    function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        e.dz = 1'b0;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else begin
                sa  = a;
                sbv = b;
                e.q = 32'(sa / sbv);
                e.r = 32'(sa % sbv);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic applyStimulus(input string tag, input bit sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expQ,
                                 input logic [31:0] expR, input logic expDz);
        exp_t e;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.data_in1  = a;
        bus.data_in2  = b;
        e.q  = expQ;
        e.r  = expR;
        e.dz = expDz;
        sb.push_back(e);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.is_signed = ~sgn;
        bus.data_in1  = ~a;
        bus.data_in2  = b ^ 32'h0000_0005;
    endtask

    task automatic checkOutput(input int edges0, input int busy0);
        int    edges;
        int    busyCycles;
        bit    seen;
        exp_t  e;
        string tag;
        edges      = edges0;
        busyCycles = busy0;
        seen       = 1'b0;
        while (!seen && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busyCycles++;
        end
        compare("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            if (sb.size() == 0) begin
                compare("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                e   = sb.pop_front();
                tag = tagQ.pop_front();
                compare({tag, "_quotient"}, bus.quotient, e.q);
                compare({tag, "_remainder"}, bus.remainder, e.r);
                compare({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dz));
                compare({tag, "_latency"}, 32'(edges), 32'd34);
                compare({tag, "_busy_cycles"}, 32'(busyCycles), 32'd33);
                compare({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
            end
            @(posedge clk);
            #1;
            compare("done_one_cycle", 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        int          pulses;

        totalCount    = 0;
        badCount      = 0;
        rst_b         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.data_in1  = '0;
        bus.data_in2  = '0;

        repeat (2) @(posedge clk);
        #1;
        compare("reset_busy", 32'(bus.busy), 32'd0);
        compare("reset_done", 32'(bus.done), 32'd0);
        compare("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        compare("reset_quotient", bus.quotient, 32'd0);
        compare("reset_remainder", bus.remainder, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        $display("[TB] directed signed/unsigned cases");
        applyStimulus("div_7_2", 1'b1, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
        checkOutput(0, 0);
        applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        checkOutput(0, 0);
        applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        checkOutput(0, 0);
        applyStimulus("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        checkOutput(0, 0);
        applyStimulus("divu_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
        checkOutput(0, 0);
        applyStimulus("divu_small", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
        checkOutput(0, 0);
        applyStimulus("div_zero_s", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        checkOutput(0, 0);
        applyStimulus("div_zero_u", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        checkOutput(0, 0);

        $display("[TB] start while busy is ignored");
        applyStimulus("ignored_start", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.data_in1 = 32'd1000;
        bus.data_in2 = 32'd3;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.data_in1 = 32'hDEAD_BEEF;
        checkOutput(4, 4);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        compare("no_extra_done", 32'(pulses), 32'd0);

        $display("[TB] randomized back-to-back ops");
        for (int i = 0; i < 6; i++) begin
            s = 1'(i % 2);
            a = $urandom;
            b = 32'($urandom_range(1, 1000));
            if (s && (i % 3 == 0)) b = -b;
            e = model(s, a, b);
            applyStimulus("random", s, a, b, e.q, e.r, e.dz);
            checkOutput(0, 0);
        end

        $display("[TB] reset in the middle of an op");
        applyStimulus("aborted", 1'b0, 32'd12345, 32'd17, 32'd726, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        compare("abort_busy", 32'(bus.busy), 32'd0);
        compare("abort_done", 32'(bus.done), 32'd0);
        compare("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        compare("abort_quotient", bus.quotient, 32'd0);
        compare("abort_remainder", bus.remainder, 32'd0);
        sb.delete();
        tagQ.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        compare("abort_no_done", 32'(pulses), 32'd0);
        applyStimulus("after_reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        checkOutput(0, 0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
